// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter must hold 0..WIDTH-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell used by the serial adder datapath.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic C0
);

  assign sum = A ^ B ^ Cin;
  assign C0  = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder, LSB first, one full-adder cell; optional signed-overflow flag
// under SERIAL_ADD_OVF_EN.
//   state    | meaning
//   ST_IDLE  | in_ready high, waiting for operands
//   ST_SHIFT | one bit pair added per cycle
//   ST_DONE  | result held with out_valid until out_ready
module bit_serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] a_d, b_d, sum_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, in_ready_q, out_valid_q;
  logic             fa_s, fa_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  fulladder u_fa (
    .A  (a_q[0]),
    .B  (b_q[0]),
    .Cin(carry_q),
    .sum(fa_s),
    .C0 (fa_c)
  );

  always_comb begin
    a_d = a_q >> 1;
    b_d = b_q >> 1;
    sum_d = sum_q >> 1;
    sum_d[WIDTH-1] = fa_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q     <= a_d;
          b_q     <= b_d;
          sum_q   <= sum_d;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cout_q      <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q here is the carry into the MSB, fa_c the carry out of it
            ovf_q       <= carry_q ^ fa_c;
`endif
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder at WIDTH=8 and WIDTH=1; ovf checked when
// SERIAL_ADD_OVF_EN is defined.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic       in_ready, out_valid, cout;
  logic       in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       in_ready1, out_valid1, cout1;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf, ovf1;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("wait_in_ready", in_ready, 1);
    in_valid = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid8(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 8);
  endtask

  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic cv, input logic [7:0] es, input logic ec, input logic eo);
    start_op8(av, bv, cv);
    wait_valid8(tag);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  logic [8:0] exp_q[$];
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf_q[$];
`endif

  initial begin
    int n, idx, last_acc, cyc, got;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] full;
    logic [7:0] low;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst1_in_ready", in_ready1, 1);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    op8("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    op8("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("msb", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
    op8("plain", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // Backpressure: result frozen, new operands pulsed in DONE must be dropped
    start_op8(8'h12, 8'h34, 1'b0);
    wait_valid8("bp");
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", out_valid, 1);
      check("bp_sum", sum, 8'h46);
      check("bp_cout", cout, 0);
      check("bp_in_ready", in_ready, 0);
      if (k == 1) begin in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
      if (k == 2) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    @(negedge clk);
    check("bp_no_accept", in_ready, 1);

    // Reset during SHIFT after three bits
    start_op8(8'hAA, 8'h55, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    repeat (10) @(negedge clk);
    check("midrst_no_valid", out_valid, 0);
    op8("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Reset and in_valid on the same edge: reset wins
    rst = 1'b1; in_valid = 1'b1; a = 8'h07; b = 8'h07;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_vs_valid_ready", in_ready, 1);
    repeat (10) @(negedge clk);
    check("rst_vs_valid_no_out", out_valid, 0);

    // Back-to-back with both handshakes held high
    idx = 0; got = 0; last_acc = -1; cyc = 0;
    out_ready = 1'b1;
    while (got < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (out_valid && exp_q.size() > 0) begin
        full = exp_q.pop_front();
        check("b2b_sum", sum, full[7:0]);
        check("b2b_cout", cout, full[8]);
`ifdef SERIAL_ADD_OVF_EN
        check("b2b_ovf", ovf, ovf_q.pop_front());
`endif
        got++;
      end
      if (in_ready && idx < 100) begin
        if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 10);
        last_acc = cyc;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        in_valid = 1'b1; a = ra; b = rb; cin = rc;
        full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
        exp_q.push_back(full);
`ifdef SERIAL_ADD_OVF_EN
        low = {1'b0, ra[6:0]} + {1'b0, rb[6:0]} + {7'd0, rc};
        ovf_q.push_back(low[7] ^ full[8]);
`endif
        idx++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end
    end
    check("b2b_count", got, 100);
    in_valid = 1'b0;
    out_ready = 1'b0;

    // WIDTH=1 instance
    @(negedge clk);
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    check("w1_not_yet", out_valid1, 0);
    @(negedge clk);
    check("w1_valid", out_valid1, 1);
    check("w1_sum", sum1, 1);
    check("w1_cout", cout1, 1);
`ifdef SERIAL_ADD_OVF_EN
    check("w1_ovf", ovf1, 0);
`endif
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("w1_drop", out_valid1, 0);
    n = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial adder that sums two WIDTH-bit operands one bit per clock, LSB first, through a single full-adder cell and a registered carry. It is the datapath stage that sits in front of the `fulladder` cell: it holds the operands and carry state and feeds the cell one bit pair per cycle. This trades WIDTH-cycle latency for one adder cell of area. Operands enter through a valid/ready handshake; results leave through a second valid/ready handshake.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is 1..64.
- `clk` input 1: sole clock. Every state element updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the operand set on `a`/`b`/`cin` is valid.
- `in_ready` output 1: the block can accept operands. It is high only in IDLE.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: initial carry-in.
- `out_valid` output 1: `sum`/`cout` hold a result.
- `out_ready` input 1: the consumer accepts the result.
- `sum` output WIDTH: registered sum.
- `cout` output 1: carry out of the MSB.
- `ovf` output 1: signed overflow. Present only with `SERIAL_ADD_OVF_EN`.

## Operation
- **Reset values:** FSM goes to IDLE. `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, bit counter=0, carry register=0.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid` & `in_ready`: load the A and B shift registers, load the carry register with `cin`, clear the counter, go to SHIFT.
- **SHIFT:**
  - Each cycle, feed A[0], B[0] and the carry register into the full-adder cell.
  - Shift the cell's sum bit into the MSB of the sum shift register and shift A and B right by one.
  - Load the cell's carry into the carry register and increment the counter.
  - The state is left on the edge that processes bit WIDTH-1 (counter == WIDTH-1), going to DONE.
- **DONE:**
  - `out_valid`=1. `sum`/`cout` are stable and do not change while `out_valid` is high.
  - On `out_ready`: `out_valid` falls and the FSM goes to IDLE.
- **Ignored inputs:** `in_valid` is ignored outside IDLE, and so is any change to `a`/`b`/`cin` after acceptance. `out_ready` is ignored outside DONE.
- **Arithmetic:** unsigned modulo 2^WIDTH. `cout` is the carry out of bit WIDTH-1.
- **WIDTH=1:** SHIFT lasts exactly one cycle.
- **Reset mid-operation:** `rst` in SHIFT or DONE aborts the operation. On the next edge all outputs are at their reset values. There is no partial result and no spurious `out_valid`.
- **`rst` with `in_valid` on the same edge:** reset wins and the operands are not accepted.

## Timing
- The accept edge is E0. Bits are processed on edges E1..E_WIDTH.
- `out_valid` is high in the cycle after E_WIDTH. Latency is WIDTH cycles from the accept edge.
- The minimum period between accepts is WIDTH+2 cycles: WIDTH SHIFT cycles, one DONE cycle with `out_ready`=1, and one IDLE cycle.
- The full-adder path is combinational within a single cycle. There is no combinational path from any input to any output.

## Configuration
- **`SERIAL_ADD_OVF_EN` defined:**
  - The `ovf` port exists.
  - On the last SHIFT edge, register `ovf` = (carry into the MSB) XOR (carry out of the MSB).
  - `ovf` is valid and stable alongside `out_valid`.
- **Not defined:** there is no `ovf` port and no overflow register. All other behaviour is identical.

## Structure
- **Package `serial_add_pkg`:**
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2. The value 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH.
  - Counter width, defined as clog2(WIDTH), minimum 1.
- **Sub-module:** exactly one instance of the existing `fulladder` cell, with inputs A, B, Cin and outputs sum, C0. No other sub-modules.

## Test plan
- **Basic add:** WIDTH=8, a=0x5A, b=0x3C, cin=0 → after 8 cycles `sum`=0x96, `cout`=0, `ovf`=1.
- **Carry wrap:** a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1, `ovf`=0. Then a=0x80, b=0x80, cin=1 → `sum`=0x01, `cout`=1, `ovf`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `sum` and `cout` stay constant. `in_ready` stays 0 and a pulse of `in_valid`=1 with new operands is not accepted.
- **Reset mid-SHIFT:** assert `rst` at bit 3 of a=0xAA, b=0x55 → next cycle `in_ready`=1, `out_valid`=0, `sum`=0. A fresh a=0x01, b=0x02 then yields `sum`=0x03.
- **Back-to-back:** `in_valid` held high and `out_ready` held high with 100 random vector pairs → every result matches a+b+cin. Accepts are spaced exactly WIDTH+2 cycles apart.
- **WIDTH=1 instance:** a=1, b=1, cin=1 → `sum`=1, `cout`=1, `out_valid` one cycle after acceptance.
